// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_pkg
// Brief  : Shared geometry constants and request struct for RAM port control.
// Rev    : 1.0  initial release
// ============================================================================
package ram_pkg;

    localparam int c_DATAWIDTH  = 32;
    localparam int c_DEPTH      = 16;
    localparam int c_READ_DELAY = 2;
    localparam int c_ADDRWIDTH  = $clog2(c_DEPTH);

    typedef struct packed {
        logic                   we;
        logic [c_ADDRWIDTH-1:0] addr;
        logic [c_DATAWIDTH-1:0] wdata;
    } ram_req_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with registered occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~w_full | w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && w_full && !pop));

endmodule
`default_nettype wire

// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram_port_ctrl
// Brief  : Valid/ready front end for one RAM port with credit-limited reads
//          and a back-pressurable, in-order response buffer.
// Rev    : 1.0  initial release
// ============================================================================
module ram_port_ctrl
    import ram_pkg::*;
#(
    parameter int DATAWIDTH  = c_DATAWIDTH,
    parameter int DEPTH      = c_DEPTH,
    parameter int READ_DELAY = c_READ_DELAY,
    parameter int RSP_DEPTH  = READ_DELAY + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [$clog2(DEPTH)-1:0]       req_addr,
    input  logic [DATAWIDTH-1:0]           req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATAWIDTH-1:0]           rsp_rdata,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [$clog2(DEPTH)-1:0]       ram_addr,
    output logic [DATAWIDTH-1:0]           ram_din,
    input  logic [DATAWIDTH-1:0]           ram_dout,
    output logic [$clog2(RSP_DEPTH+1)-1:0] rd_outstanding
);

    localparam int CW = $clog2(RSP_DEPTH+1);
    localparam int KW = $clog2(READ_DELAY + RSP_DEPTH + 1) + 1;

    logic [READ_DELAY-1:0] r_vld;
    logic [KW-1:0]         w_inflight;
    logic [KW-1:0]         w_credits;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_accept;
    logic                  w_rd_acc;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_DELAY; i++) begin
            w_inflight = w_inflight + KW'(r_vld[i]);
        end
    end

    // A pop this cycle frees a slot for a read accepted on the same edge.
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_credits = w_inflight + KW'(w_fifo_count) - KW'(w_pop);
    assign req_ready = rst_n & (req_we | (w_credits < KW'(RSP_DEPTH)));
    assign w_accept  = req_valid & req_ready;
    assign w_rd_acc  = w_accept & ~req_we;

    assign ram_en   = w_accept;
    assign ram_we   = rst_n & req_we;
    assign ram_addr = rst_n ? req_addr  : '0;
    assign ram_din  = rst_n ? req_wdata : '0;

    generate
        if (READ_DELAY == 1) begin : g_vld_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= w_rd_acc;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= {r_vld[READ_DELAY-2:0], w_rd_acc};
            end
        end
    endgenerate

    assign w_push = r_vld[READ_DELAY-1];

    sync_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (ram_dout),
        .pop       (w_pop),
        .pop_data  (rsp_rdata),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign rsp_valid      = ~w_fifo_empty;
    assign rd_outstanding = CW'(w_inflight) + w_fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_ram_port_ctrl
// Brief  : Directed and scoreboarded bench with a 32x16, 2-cycle RAM model.
// ============================================================================
module tb_ram_port_ctrl;
    import ram_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int RD  = 2;
    localparam int RSP = 3;
    localparam int OW  = 2;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [OW-1:0] rd_outstanding;

    int vectors = 0;
    int errors  = 0;

    ram_port_ctrl #(.DATAWIDTH(DW), .DEPTH(16), .READ_DELAY(RD), .RSP_DEPTH(RSP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .rd_outstanding(rd_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-A model of ram_2p: word sampled on the enable edge, visible RD edges later.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_pipe [RD];
    always_ff @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) ram_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_dout = ram_pipe[RD-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5;
        req_wdata = '1; rsp_ready = 1'b0;
        tick(); tick();
        vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        vectors++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rd_outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", rd_outstanding); end
        req_valid = 1'b0; req_we = 1'b0; rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tick();
    endtask

    task automatic test_write_read();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 32'hDEADBEEF; rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        vectors++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL wr_strobes: got en=%b we=%b want 1 1", ram_en, ram_we); end
        vectors++; if (ram_addr !== 4'd3 || ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_pass: got addr=%h din=%h want 3 deadbeef", ram_addr, ram_din); end
        tick();
        req_we = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1 || ram_en !== 1'b1) begin errors++; $display("FAIL rd_accept: got ready=%b en=%b want 1 1", req_ready, ram_en); end
        tick();
        req_valid = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1: got %b want 0", rsp_valid); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat2: got %b want 0", rsp_valid); end
        tick();
        vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_lat3: got v=%b d=%h want 1 deadbeef", rsp_valid, rsp_rdata); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(i); req_wdata = DW'(i) * 32'h11111111;
            tick();
        end
        rsp_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            req_valid = (j < 8); req_we = 1'b0; req_addr = AW'(j);
            #1;
            if (j < 8) begin
                vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", j, req_ready); end
            end
            vectors++; if (rsp_valid !== (j >= 3 && j < 11)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", j, rsp_valid, (j >= 3 && j < 11)); end
            if (j >= 3 && j < 11) begin
                exp_d = DW'(j - 3) * 32'h11111111;
                vectors++; if (rsp_rdata !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", j, rsp_rdata, exp_d); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [DW-1:0] exp_d;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(acc);
            #1;
            vectors++; if (req_ready !== (i < 3)) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready, (i < 3)); end
            if (req_ready) acc++;
            tick();
        end
        vectors++; if (rd_outstanding !== 2'd3) begin errors++; $display("FAIL bp_outstanding: got %0d want 3", rd_outstanding); end
        req_we = 1'b1; req_addr = 4'd15; req_wdata = 32'hA5A5A5A5;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_write_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = DW'(i) * 32'h11111111;
            vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want 1 %h", i, rsp_valid, rsp_rdata, exp_d); end
            tick();
        end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
    endtask

    task automatic test_random();
        logic [DW-1:0] model_mem [16];
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] exp_d;
        ram_req_t cur;
        logic pend = 1'b0;
        logic pop;
        logic exp_rdy;
        int ops = 0;
        for (int i = 0; i < 16; i++) begin
            exp_d = $urandom;
            model_mem[i] = exp_d;
            req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(i); req_wdata = exp_d;
            tick();
        end
        cur = '0;
        for (int cyc = 0; cyc < 3000 && ops < 200; cyc++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                cur.we = ($urandom_range(0, 2) == 0);
                cur.addr = AW'($urandom_range(0, 15));
                cur.wdata = $urandom;
                pend = 1'b1;
            end
            req_valid = pend; req_we = cur.we; req_addr = cur.addr; req_wdata = cur.wdata;
            rsp_ready = $urandom_range(0, 1) != 0;
            #1;
            vectors++; if (int'(rd_outstanding) != exp_q.size()) begin errors++; $display("FAIL rnd_outstanding[%0d]: got %0d want %0d", cyc, rd_outstanding, exp_q.size()); end
            pop = rsp_valid & rsp_ready;
            if (pop) begin
                vectors++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra[%0d]: got %h want no response", cyc, rsp_rdata); end
                else begin
                    exp_d = exp_q.pop_front();
                    if (rsp_rdata !== exp_d) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, rsp_rdata, exp_d); end
                end
            end
            if (pend) begin
                exp_rdy = cur.we || (exp_q.size() < RSP);
                vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_rdy); end
                if (req_ready) begin
                    if (cur.we) model_mem[cur.addr] = cur.wdata;
                    else exp_q.push_back(model_mem[cur.addr]);
                    pend = 1'b0;
                    ops++;
                end
            end
            tick();
        end
        vectors++; if (ops < 200) begin errors++; $display("FAIL rnd_timeout: got %0d ops want 200", ops); end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            #1;
            if (rsp_valid) begin
                exp_d = exp_q.pop_front();
                vectors++; if (rsp_rdata !== exp_d) begin errors++; $display("FAIL rnd_drain[%0d]: got %h want %h", cyc, rsp_rdata, exp_d); end
            end
            tick();
        end
        #1;
        vectors++; if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_final: got left=%0d v=%b want 0 0", exp_q.size(), rsp_valid); end
        tick();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
            tick();
        end
        req_addr = 4'd4;
        #1;
        vectors++; if (rd_outstanding !== 2'd3 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got out=%0d v=%b want 3 1", rd_outstanding, rsp_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ram_en !== 1'b0 || rsp_valid !== 1'b0 || rd_outstanding !== 2'd0) begin errors++; $display("FAIL mid_assert: got en=%b v=%b out=%0d want 0 0 0", ram_en, rsp_valid, rd_outstanding); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL mid_en[%0d]: got %b want 0", i, ram_en); end
        end
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (rsp_valid !== 1'b0 || rd_outstanding !== 2'd0) begin errors++; $display("FAIL mid_post[%0d]: got v=%b out=%0d want 0 0", i, rsp_valid, rd_outstanding); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
